// File: rtl/code_entry.sv
// code_entry: keypad digit collector for the cycle-lock compare path.
// Digits are shifted in MSB-first. A completed code is either handed to the
// checker over a valid/ready handshake or, in enroll mode, written into the
// stored-key register. Partial codes are dropped on clear or inactivity.
module code_entry #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter logic [DIGITS*DIGIT_W-1:0] KEY_INIT = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_valid,
  output logic                             digit_ready,
  input  logic                             clear,
  input  logic                             enroll,
  output logic [DIGITS*DIGIT_W-1:0]        code_out,
  output logic                             code_valid,
  input  logic                             code_ready,
  output logic [DIGITS*DIGIT_W-1:0]        key_out,
  output logic                             key_wr,
  output logic [$clog2(DIGITS+1)-1:0]      count,
  output logic                             timeout_err
);

  localparam int unsigned W  = DIGITS * DIGIT_W;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   code_q, code_d;
  logic           cvalid_q, cvalid_d;
  logic [W-1:0]   key_q, key_d;
  logic           key_wr_q, key_wr_d;
  logic           tmo_q, tmo_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic           enf_q, enf_d;
  logic [W-1:0]   full_word;
  logic           mode_enroll;

  assign full_word   = {shift_q[W-DIGIT_W-1:0], digit_in};
  assign digit_ready = (state_q == COLLECT);
  assign code_out    = code_q;
  assign code_valid  = cvalid_q;
  assign key_out     = key_q;
  assign key_wr      = key_wr_q;
  assign count       = count_q;
  assign timeout_err = tmo_q;

  // Register all state; reset restores an empty collector and the initial key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      count_q  <= '0;
      shift_q  <= '0;
      code_q   <= '0;
      cvalid_q <= 1'b0;
      key_q    <= KEY_INIT;
      key_wr_q <= 1'b0;
      tmo_q    <= 1'b0;
      idle_q   <= '0;
      enf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      code_q   <= code_d;
      cvalid_q <= cvalid_d;
      key_q    <= key_d;
      key_wr_q <= key_wr_d;
      tmo_q    <= tmo_d;
      idle_q   <= idle_d;
      enf_q    <= enf_d;
    end
  end

  // Next-state: digit capture, code completion, clear and idle timeout.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    code_d      = code_q;
    cvalid_d    = cvalid_q;
    key_d       = key_q;
    key_wr_d    = 1'b0;
    tmo_d       = 1'b0;
    idle_d      = idle_q;
    enf_d       = enf_q;
    // Mode is latched on the first digit; later digits reuse the stored flag.
    mode_enroll = (count_q == '0) ? enroll : enf_q;
    unique case (state_q)
      COLLECT: begin
        if (clear) begin
          // clear also suppresses a same-cycle digit and any timeout expiry
          count_d = '0;
          shift_d = '0;
          idle_d  = '0;
        end else if (digit_valid) begin
          shift_d = full_word;
          idle_d  = '0;
          enf_d   = mode_enroll;
          if (count_q == LAST) begin
            count_d = '0;
            if (mode_enroll) begin
              key_d    = full_word;
              key_wr_d = 1'b1;
            end else begin
              code_d   = full_word;
              cvalid_d = 1'b1;
              state_d  = HOLD;
            end
          end else begin
            count_d = count_q + CW'(1);
          end
        end else if (count_q != '0) begin
          if (idle_q == TMAX) begin
            count_d = '0;
            shift_d = '0;
            idle_d  = '0;
            tmo_d   = 1'b1;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      HOLD: begin
        idle_d = '0;
        if (code_ready) begin
          cvalid_d = 1'b0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: doc/code_entry.md
Name: code_entry

Overview:
- Entry-side producer for the cycle-lock compare path. Collects keypad digits one at a time over a valid/ready handshake and assembles them MSB-first into a 16-bit candidate code.
- In normal mode the assembled code goes to the downstream checker over a valid/ready handshake.
- In enroll mode the assembled code is written into the stored-key register, which drives the checker's reference word.
- Also handles clear, inactivity timeout, and stored-key ownership.

Parameters:
- DIGITS, 4, number of digits per code; code width = DIGITS*DIGIT_W
- DIGIT_W, 4, bits per digit
- TIMEOUT, 1000, idle cycles allowed between digits before a partial code is discarded (must be >= 1)
- KEY_INIT, 16'h0000, stored-key value after reset (width DIGITS*DIGIT_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- digit_in  in  DIGIT_W  digit value
- digit_valid  in  1  digit_in is valid this cycle
- digit_ready  out  1  block accepts a digit this cycle
- clear  in  1  discard the partial code
- enroll  in  1  mode select, sampled when the first digit of a code is accepted
- code_out  out  DIGITS*DIGIT_W  assembled candidate code
- code_valid  out  1  code_out is valid for the checker
- code_ready  in  1  checker accepts code_out
- key_out  out  DIGITS*DIGIT_W  stored key (reference word)
- key_wr  out  1  one-cycle pulse when key_out has been updated
- count  out  clog2(DIGITS+1)  digits accepted in the current code
- timeout_err  out  1  one-cycle pulse when a partial code is discarded by timeout

Behaviour:
- Reset (async, rst_n=0), all outputs and state forced immediately:
  - state=COLLECT, count=0, shift register=0, code_out=0, code_valid=0
  - key_out=KEY_INIT, key_wr=0, timeout_err=0
  - idle counter=0, enroll flag=0
  - digit_ready=1 after reset release.
- States: COLLECT and HOLD.
- COLLECT:
  - digit_ready=1.
  - A digit is accepted on any clk edge with digit_valid=1 and clear=0.
  - On acceptance: shift register <= {shift[W-DIGIT_W-1:0], digit_in}, so the first digit ends up in bits [W-1:W-DIGIT_W]. count increments.
  - On the first digit (count==0): enroll flag <= enroll. Changes to enroll later in the same code are ignored.
  - On the DIGITS-th accepted digit, the full word is {shift[W-DIGIT_W-1:0], digit_in}:
    - Enroll flag=0: code_out <= full word, code_valid <= 1, state <= HOLD, count <= 0. Results visible the cycle after acceptance.
    - Enroll flag=1: key_out <= full word, key_wr pulses 1 for the next cycle, state stays COLLECT, count <= 0, code_valid stays 0.
- HOLD:
  - digit_ready=0; digit_valid is ignored.
  - code_valid and code_out are held stable until code_ready=1 on a clk edge.
  - On that edge, code_valid <= 0 and state <= COLLECT. digit_ready=1 on the following cycle.
  - code_ready while code_valid=0 has no effect.
- clear:
  - In COLLECT: count <= 0, shift <= 0, idle counter <= 0.
  - clear overrides digit_valid in the same cycle; that digit is not accepted.
  - In HOLD: ignored; the pending code is committed.
- Timeout:
  - The idle counter runs only in COLLECT with count>0. It resets to 0 on every accepted digit.
  - When it reaches TIMEOUT-1 with no digit that cycle: count <= 0, shift <= 0, timeout_err pulses 1 for one cycle, idle counter <= 0.
  - A digit accepted on the same edge as expiry wins: no timeout, and the digit is accepted.
  - Idle counter is held at 0 when count==0 and in HOLD.
- Keys: key_out changes only by an enroll completion or by reset. A reset mid-code discards the partial code and restores KEY_INIT.
- Simultaneous events: clear and a timeout expiry in the same cycle → clear wins; timeout_err is not pulsed.

Test Plan:
- Reset, then enter digits 1,2,3,4 (enroll=0) with code_ready=1 → code_valid=1 one cycle after the 4th digit, code_out=16'h1234. Drops to 0 next cycle. key_out stays 16'h0000.
- enroll=1 on the first digit (then enroll=0), enter A,B,C,D → key_out=16'hABCD with a one-cycle key_wr pulse. code_valid never asserts.
- Enter 5,6,7,8 with code_ready=0 for 10 cycles → code_out=16'h5678 stable and digit_ready=0 throughout. digit_valid pulses during HOLD are ignored. code_ready=1 → code_valid=0 next cycle.
- Enter 1,2, then clear together with digit_valid (digit 9), then 3,4,5,6 → code_out=16'h3456. The 9 is not captured.
- TIMEOUT=8: enter 7, idle 8 cycles → timeout_err single pulse, count=0. Then 1,2,3,4 → 16'h1234. Repeat with a digit on the expiry cycle → no timeout_err, and the digit is accepted.
- After enrolling 16'hABCD, enter 9,9 and drop rst_n mid-code → key_out=16'h0000 immediately, count=0, code_valid=0.
